// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Holds PS2_CLK low to
//                request to send, issues the start bit, shifts one command
//                byte plus odd parity and stop on device clock falling edges,
//                then samples the device ACK and waits for the bus to idle.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 6000,
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int IDLE_WAIT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_INHIBIT   = 3'd1;
  localparam logic [2:0] c_RELEASE   = 3'd2;
  localparam logic [2:0] c_SHIFT     = 3'd3;
  localparam logic [2:0] c_ACK       = 3'd4;
  localparam logic [2:0] c_WAIT_IDLE = 3'd5;
  localparam logic [2:0] c_DONE      = 3'd6;

  localparam logic [31:0] c_INH_LAST = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] c_TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] c_IW_LAST  = 32'(IDLE_WAIT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic        r_clk_meta, r_clk_sync, r_clk_prev;
  logic        r_dat_meta, r_dat_sync;
  logic [31:0] r_timer;
  logic [3:0]  r_idx;
  logic [9:0]  r_frame;
  logic        r_dat_low;
  logic        r_ack_ok;
  logic        w_clk_fall;
  logic        w_inhibit_last;
  logic        w_timeout;

  assign w_clk_fall     = r_clk_prev & ~r_clk_sync;
  assign w_inhibit_last = (r_state == c_INHIBIT) && (r_timer == c_INH_LAST);
  assign w_timeout      = (((r_state == c_RELEASE) || (r_state == c_SHIFT) ||
                            (r_state == c_ACK)) && (r_timer == c_TO_LAST)) ||
                          ((r_state == c_WAIT_IDLE) && (r_timer == c_IW_LAST));

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; a timeout overrides any bus event in the same cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:      if (send) w_state_next = c_INHIBIT;
      c_INHIBIT:   if (w_inhibit_last) w_state_next = c_RELEASE;
      c_RELEASE:   w_state_next = w_timeout ? c_DONE : c_SHIFT;
      c_SHIFT: begin
        if (w_timeout)                        w_state_next = c_DONE;
        else if (w_clk_fall && r_idx == 4'd9) w_state_next = c_ACK;
      end
      c_ACK: begin
        if (w_timeout)       w_state_next = c_DONE;
        else if (w_clk_fall) w_state_next = c_WAIT_IDLE;
      end
      c_WAIT_IDLE: begin
        if (w_timeout)                      w_state_next = c_DONE;
        else if (r_clk_sync && r_dat_sync)  w_state_next = c_DONE;
      end
      c_DONE:      w_state_next = c_IDLE;
      default:     w_state_next = c_IDLE;
    endcase
  end

  // Pad synchronisers, cycle timer, frame shifting and ACK capture
  always_ff @(posedge clock) begin
    if (reset) begin
      // Idle bus level is high, so start the synchronisers there to avoid a
      // false falling edge right after reset.
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_timer    <= '0;
      r_idx      <= '0;
      r_frame    <= '0;
      r_dat_low  <= 1'b0;
      r_ack_ok   <= 1'b0;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_dat_in;
      r_dat_sync <= r_dat_meta;
      case (r_state)
        c_IDLE: begin
          if (send) begin
            r_frame  <= {1'b1, ~^tx_byte, tx_byte};
            r_ack_ok <= 1'b0;
            r_timer  <= '0;
          end
        end
        c_INHIBIT: begin
          if (w_inhibit_last) begin
            r_timer   <= '0;
            r_dat_low <= 1'b1;
            r_idx     <= '0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        c_RELEASE: begin
          r_timer <= r_timer + 32'd1;
          r_idx   <= '0;
        end
        c_SHIFT: begin
          r_timer <= r_timer + 32'd1;
          if (w_timeout) begin
            r_dat_low <= 1'b0;
          end else if (w_clk_fall) begin
            r_dat_low <= ~r_frame[r_idx];
            r_idx     <= r_idx + 4'd1;
          end
        end
        c_ACK: begin
          r_timer   <= r_timer + 32'd1;
          r_dat_low <= 1'b0;
          if (!w_timeout && w_clk_fall) begin
            r_ack_ok <= ~r_dat_sync;
            r_timer  <= '0;
          end
        end
        c_WAIT_IDLE: begin
          r_timer <= r_timer + 32'd1;
          if (w_timeout) r_ack_ok <= 1'b0;
        end
        default: r_dat_low <= 1'b0;
      endcase
    end
  end

  // Outputs decoded from state; the clock line is only ever pulled in INHIBIT
  always_comb begin
    ps2_clk_drive_low = (r_state == c_INHIBIT);
    ps2_dat_drive_low = w_inhibit_last |
                        (((r_state == c_RELEASE) || (r_state == c_SHIFT)) & r_dat_low);
    busy              = (r_state != c_IDLE) && (r_state != c_DONE);
    done              = (r_state == c_DONE);
    error             = (r_state == c_DONE) & ~r_ack_ok;
    ack_ok            = r_ack_ok;
  end

endmodule
`default_nettype wire
